// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide: one bit per cycle (shift-add multiply, restoring divide).
// Latency: W+1 edges after start is sampled; divide-by-zero and signed overflow take 1 edge.
// Backpressure: stall = start & ~done holds the core; start is ignored outside IDLE.
module mdu_iter #(
    parameter int BUS_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2:0]           funct3,
    input  logic [BUS_WIDTH-1:0] rs1,
    input  logic [BUS_WIDTH-1:0] rs2,
    output logic                 busy,
    output logic                 done,
    output logic                 stall,
    output logic [BUS_WIDTH-1:0] result
);

    localparam int W  = BUS_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      op_q;
    logic            neg_ab_q;
    logic            neg_a_q;
    logic [W-1:0]    mag_a_q;
    logic [W-1:0]    mag_b_q;
    logic [W-1:0]    rem_q;
    logic [2*W-1:0]  acc_q;
    logic            done_q;
    logic [W-1:0]    result_q;

    // Operand decode, only meaningful while IDLE samples a new op
    logic         is_div, sgn_a, sgn_b, a_neg, b_neg;
    logic         div_zero, div_ovf, fast;
    logic [W-1:0] mag_a, mag_b;

    assign is_div   = funct3[2];
    assign sgn_a    = is_div ? ~funct3[0] : (funct3 != 3'd3);
    assign sgn_b    = is_div ? ~funct3[0] : ~funct3[1];
    assign a_neg    = sgn_a & rs1[W-1];
    assign b_neg    = sgn_b & rs2[W-1];
    assign mag_a    = a_neg ? -rs1 : rs1;
    assign mag_b    = b_neg ? -rs2 : rs2;
    assign div_zero = is_div & (rs2 == '0);
    assign div_ovf  = is_div & ~funct3[0] & (rs1 == MIN_NEG) & (rs2 == '1);
    assign fast     = div_zero | div_ovf;

    // Single iteration step for both operations
    logic [W:0]   mul_sum;
    logic [W:0]   div_shift;
    logic         div_ge;
    logic [W-1:0] div_rem;

    assign mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mag_a_q} : '0);
    assign div_shift = {rem_q, acc_q[W-1]};
    assign div_ge    = div_shift >= {1'b0, mag_b_q};
    assign div_rem   = div_shift[W-1:0] - mag_b_q;

    // Sign correction and half/quotient/remainder selection
    logic [2*W-1:0] prod;
    logic [W-1:0]   quo, rem_fix, sel;

    assign prod    = neg_ab_q ? -acc_q : acc_q;
    assign quo     = neg_ab_q ? -acc_q[W-1:0] : acc_q[W-1:0];
    assign rem_fix = neg_a_q ? -rem_q : rem_q;

    always_comb begin
        sel = rem_fix;
        case (op_q)
            3'd0:             sel = prod[W-1:0];
            3'd1, 3'd2, 3'd3: sel = prod[2*W-1:W];
            3'd4, 3'd5:       sel = quo;
            default:          sel = rem_fix;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = fast ? FIN : RUN;
            RUN:     if (cnt_q == CW'(W-1)) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            op_q     <= '0;
            neg_ab_q <= 1'b0;
            neg_a_q  <= 1'b0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            rem_q    <= '0;
            acc_q    <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q     <= funct3;
                        cnt_q    <= '0;
                        mag_a_q  <= mag_a;
                        mag_b_q  <= mag_b;
                        // Fast-path results are preloaded so FIN selects them unchanged
                        neg_ab_q <= (a_neg ^ b_neg) & ~fast;
                        neg_a_q  <= a_neg & ~fast;
                        if (div_zero) begin
                            acc_q <= {{W{1'b0}}, {W{1'b1}}};
                            rem_q <= rs1;
                        end else if (div_ovf) begin
                            acc_q <= {{W{1'b0}}, MIN_NEG};
                            rem_q <= '0;
                        end else if (is_div) begin
                            acc_q <= {{W{1'b0}}, mag_a};
                            rem_q <= '0;
                        end else begin
                            acc_q <= {{W{1'b0}}, mag_b};
                            rem_q <= '0;
                        end
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (op_q[2]) begin
                        acc_q <= {acc_q[2*W-1:W], acc_q[W-2:0], div_ge};
                        rem_q <= div_ge ? div_rem : div_shift[W-1:0];
                    end else begin
                        acc_q <= {mul_sum, acc_q[W-1:1]};
                    end
                end
                FIN: begin
                    result_q <= sel;
                    done_q   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = done_q;
    assign stall  = start & ~done_q;
    assign result = result_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed and random bench for mdu_iter with a queue of expected writeback values.
module tb_mdu_iter;

    localparam int W = 32;

    logic          clk;
    logic          rst;
    logic          start;
    logic [2:0]    funct3;
    logic [W-1:0]  rs1;
    logic [W-1:0]  rs2;
    logic          busy;
    logic          done;
    logic          stall;
    logic [W-1:0]  result;

    int            tests = 0;
    int            fails = 0;
    logic [W-1:0]  exp_q[$];

    mdu_iter #(.BUS_WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .rs1    (rs1),
        .rs2    (rs2),
        .busy   (busy),
        .done   (done),
        .stall  (stall),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        longint      qa, qb, r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'h0, a};
        ub = {32'h0, b};
        qa = longint'($signed(sa));
        qb = longint'($signed(sb));
        p  = 64'h0;
        r  = 0;
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                r = qa / qb;
                return r[31:0];
            end
            3'd5: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'h0) return a;
                r = qa % qb;
                return r[31:0];
            end
            default: return (b == 32'h0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    // Waits for done, counting edges after the sampling edge and busy cycles.
    task automatic wait_done(input string tag, input int exp_edges, input int exp_busy,
                             input bit mid_change);
        int          n = 0;
        int          nb = 0;
        bit          got = 1'b0;
        bit          stall_ok = 1'b1;
        logic [31:0] exp;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            if (busy) nb++;
            if (done) begin
                got = 1'b1;
                if (stall !== 1'b0) stall_ok = 1'b0;
            end else if (start && stall !== 1'b1) begin
                stall_ok = 1'b0;
            end
            if (mid_change && n == 10) begin
                rs1    = 32'h1234_5678;
                rs2    = 32'h0;
                funct3 = 3'd0;
            end
        end
        chk({tag, "_done_seen"}, 64'(got), 64'd1);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        if (got) begin
            chk({tag, "_result"}, 64'(result), 64'(exp));
            chk({tag, "_latency"}, 64'(n - 1), 64'(exp_edges));
            chk({tag, "_busy_cycles"}, 64'(nb), 64'(exp_busy));
            chk({tag, "_stall"}, 64'(stall_ok), 64'd1);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input bit fast);
        @(negedge clk);
        funct3 = f;
        rs1    = a;
        rs2    = b;
        start  = 1'b1;
        exp_q.push_back(exp);
        wait_done(tag, fast ? 1 : W + 1, fast ? 0 : W, 1'b0);
        start = 1'b0;
    endtask

    initial begin
        int dcnt;
        rst    = 1'b0;
        start  = 1'b0;
        funct3 = 3'd0;
        rs1    = '0;
        rs2    = '0;
        #3;
        chk("reset_result", 64'(result), 64'h0);
        chk("reset_busy", 64'(busy), 64'h0);
        chk("reset_done", 64'(done), 64'h0);
        chk("reset_stall", 64'(stall), 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        run_op("mul_7_m6", 3'd0, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0);
        @(negedge clk);
        chk("mul_done_one_cycle", 64'(done), 64'h0);
        chk("mul_result_held", 64'(result), 64'hFFFF_FFD6);
        run_op("mulh_7_m6", 3'd1, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 1'b0);
        run_op("mulhu_7_m6", 3'd3, 32'd7, 32'hFFFF_FFFA, 32'h0000_0006, 1'b0);

        run_op("div_m20_3", 3'd4, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 1'b0);
        run_op("rem_m20_3", 3'd6, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 1'b0);
        run_op("divu_big_3", 3'd5, 32'hFFFF_FFEC, 32'd3, 32'h5555_554E, 1'b0);
        run_op("remu_big_3", 3'd7, 32'hFFFF_FFEC, 32'd3, 32'h0000_0002, 1'b0);

        run_op("divu_by_0", 3'd5, 32'd123, 32'd0, 32'hFFFF_FFFF, 1'b1);
        run_op("rem_by_0", 3'd6, 32'd123, 32'd0, 32'd123, 1'b1);
        run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);

        // Back-to-back MULHSU with start held, operands disturbed mid-run
        @(negedge clk);
        funct3 = 3'd2;
        rs1    = 32'hFFFF_FFFF;
        rs2    = 32'd2;
        start  = 1'b1;
        exp_q.push_back(32'hFFFF_FFFF);
        wait_done("b2b_first", W + 1, W, 1'b1);
        funct3 = 3'd2;
        rs1    = 32'hFFFF_FFFF;
        rs2    = 32'd2;
        exp_q.push_back(32'hFFFF_FFFF);
        wait_done("b2b_second", W + 1, W, 1'b0);
        start = 1'b0;

        // Reset while the counter sits at 15
        @(negedge clk);
        funct3 = 3'd0;
        rs1    = 32'd9;
        rs2    = 32'd11;
        start  = 1'b1;
        repeat (16) @(negedge clk);
        chk("prereset_busy", 64'(busy), 64'h1);
        rst = 1'b0;
        #1;
        chk("midrun_rst_result", 64'(result), 64'h0);
        chk("midrun_rst_busy", 64'(busy), 64'h0);
        chk("midrun_rst_done", 64'(done), 64'h0);
        chk("midrun_rst_stall", 64'(stall), 64'h1);
        @(negedge clk);
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        dcnt  = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("aborted_no_done", 64'(dcnt), 64'h0);
        chk("aborted_idle", 64'(busy), 64'h0);
        run_op("mul_3_5_after_rst", 3'd0, 32'd3, 32'd5, 32'd15, 1'b0);

        for (int i = 0; i < 32; i++) begin
            logic [2:0]  f;
            logic [31:0] a, b;
            bit          fst;
            f   = 3'(i % 8);
            a   = pick();
            b   = pick();
            fst = f[2] && (b == 32'h0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
            run_op($sformatf("rand%0d_f%0d", i, f), f, a, b, ref_model(f, a, b), fst);
        end

        chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
